energy_tracker: RTL and testbench

Downstream stage of the matrix-multiply energy accumulator in the Ising annealing datapath. For each sweep it takes the final signed energy of one sigma^T·J·sigma evaluation and the sigma vector that produced it. It compares the energy against the best seen so far, keeps the best energy and best sigma, and counts iterations and non-improving evaluations. It ends the run on an iteration limit or a stall limit, and feeds `best_energy` back as the accumulator's `Energy_previous`.

---
 rtl/ising_pkg.sv | 25 ++
 rtl/sat_counter.sv | 32 +++
 rtl/energy_tracker.sv | 121 ++++++++++++
 tb/tb_energy_tracker.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ising_pkg.sv
// Shared types and constants for the Ising annealing datapath.
package ising_pkg;

  // Signed width of sigma^T*J*sigma for VECTOR_SIZE spins and J elements of j_width bits.
  function automatic int energy_width(input int vector_size, input int j_width);
    return 2 * $clog2(vector_size) + j_width + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } tracker_state_t;

  localparam int DONE_ITER_BIT  = 0;
  localparam int DONE_STALL_BIT = 1;
  typedef logic [1:0] done_reason_t;

  // Most positive signed value of the given width (sign bit 0, rest ones).
  function automatic logic [63:0] max_energy(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at MAX.
// Latency: count updates on the enabling edge; count_nxt previews it. No backpressure.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_nxt
);

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (en && (count != MAX)) begin
      count_nxt = count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/energy_tracker.sv
// Keeps the best energy/sigma of an annealing run and ends it on an iteration or stall limit.
// Latency: one cycle from energy_valid to accept/reject and state; accepts one evaluation per cycle, no backpressure.
module energy_tracker
  import ising_pkg::*;
#(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int ENERGY_WIDTH    = energy_width(VECTOR_SIZE, J_ELEMENT_WIDTH),
  parameter int ITER_WIDTH      = 16,
  parameter int STALL_LIMIT     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [ITER_WIDTH-1:0]               max_iters,
  input  logic                                energy_valid,
  input  logic signed [ENERGY_WIDTH-1:0]      energy_in,
  input  logic [VECTOR_SIZE-1:0]              sigma_in,
  output logic signed [ENERGY_WIDTH-1:0]      best_energy,
  output logic [VECTOR_SIZE-1:0]              best_sigma,
  output logic                                accept,
  output logic                                reject,
  output logic [ITER_WIDTH-1:0]               iter_count,
  output logic [$clog2(STALL_LIMIT+1)-1:0]    stall_count,
  output logic                                busy,
  output logic                                done,
  output done_reason_t                        done_reason
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic signed [ENERGY_WIDTH-1:0] E_MAX =
    $signed(ENERGY_WIDTH'(max_energy(ENERGY_WIDTH)));
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  tracker_state_t          state;
  logic [ITER_WIDTH-1:0]   max_iters_q;
  logic [ITER_WIDTH-1:0]   iter_nxt;
  logic [STALL_W-1:0]      stall_nxt;
  logic                    live;
  logic                    take;
  logic                    better;
  logic                    iter_hit;
  logic                    stall_hit;

  // start wins over a coincident evaluation, which is simply dropped.
  assign live   = (state == ST_FIRST) || (state == ST_RUN);
  assign take   = energy_valid && !start && live;
  assign better = (state == ST_FIRST) || (energy_in < best_energy);

  sat_counter #(
    .WIDTH (ITER_WIDTH),
    .MAX   ('1)
  ) u_iter_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .en        (take),
    .count     (iter_count),
    .count_nxt (iter_nxt)
  );

  sat_counter #(
    .WIDTH (STALL_W),
    .MAX   (STALL_MAX)
  ) u_stall_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (start || (take && better)),
    .en        (take && !better),
    .count     (stall_count),
    .count_nxt (stall_nxt)
  );

  // Limits are judged on the counts this evaluation produces, not the stale ones.
  assign iter_hit  = (max_iters_q != '0) && (iter_nxt == max_iters_q);
  assign stall_hit = (stall_nxt == STALL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      max_iters_q <= '0;
      best_energy <= E_MAX;
      best_sigma  <= '0;
      accept      <= 1'b0;
      reject      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_reason <= '0;
    end else begin
      accept <= 1'b0;
      reject <= 1'b0;
      if (start) begin
        state       <= ST_FIRST;
        busy        <= 1'b1;
        done        <= 1'b0;
        max_iters_q <= max_iters;
        best_energy <= E_MAX;
        best_sigma  <= '0;
        done_reason <= '0;
      end else if (take) begin
        if (better) begin
          best_energy <= energy_in;
          best_sigma  <= sigma_in;
          accept      <= 1'b1;
        end else begin
          reject <= 1'b1;
        end
        if (iter_hit || stall_hit) begin
          state                       <= ST_DONE;
          busy                        <= 1'b0;
          done                        <= 1'b1;
          done_reason[DONE_ITER_BIT]  <= iter_hit;
          done_reason[DONE_STALL_BIT] <= stall_hit;
        end else begin
          state <= ST_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_energy_tracker.sv
// Randomized bench for energy_tracker against a run-level model, plus directed literal checks.
module tb_energy_tracker;

  localparam int  VS    = 256;
  localparam int  EW    = 21;
  localparam int  SL    = 3;
  localparam longint EMAX = 1048575;
  localparam longint EMIN = -1048576;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [15:0]          max_iters;
  logic                 energy_valid;
  logic signed [EW-1:0] energy_in;
  logic [VS-1:0]        sigma_in;
  logic signed [EW-1:0] best_energy;
  logic [VS-1:0]        best_sigma;
  logic                 accept;
  logic                 reject;
  logic [15:0]          iter_count;
  logic [1:0]           stall_count;
  logic                 busy;
  logic                 done;
  logic [1:0]           done_reason;

  energy_tracker #(
    .VECTOR_SIZE     (VS),
    .J_ELEMENT_WIDTH (4),
    .ITER_WIDTH      (16),
    .STALL_LIMIT     (SL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .max_iters    (max_iters),
    .energy_valid (energy_valid),
    .energy_in    (energy_in),
    .sigma_in     (sigma_in),
    .best_energy  (best_energy),
    .best_sigma   (best_sigma),
    .accept       (accept),
    .reject       (reject),
    .iter_count   (iter_count),
    .stall_count  (stall_count),
    .busy         (busy),
    .done         (done),
    .done_reason  (done_reason)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_sig(input string name, input logic [VS-1:0] act, input logic [VS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act[63:0], exp[63:0], $time);
    end
  endtask

  // Run-level model: a run is either live (collecting), finished, or absent.
  bit            chk_en   = 0;
  bit            m_live   = 0;
  bit            m_seen   = 0;
  bit            m_done   = 0;
  longint        m_best   = EMAX;
  logic [VS-1:0] m_sig    = '0;
  int            m_iters  = 0;
  int            m_stall  = 0;
  int            m_max    = 0;
  bit            m_acc    = 0;
  bit            m_rej    = 0;
  bit [1:0]      m_reason = 0;

  always @(posedge clk) begin
    longint e;
    m_acc = 0;
    m_rej = 0;
    if (rst) begin
      chk_en = 1;
      m_live = 0; m_seen = 0; m_done = 0; m_best = EMAX; m_sig = '0;
      m_iters = 0; m_stall = 0; m_max = 0; m_reason = 0;
    end else if (start) begin
      m_live = 1; m_seen = 0; m_done = 0; m_best = EMAX; m_sig = '0;
      m_iters = 0; m_stall = 0; m_max = int'(max_iters); m_reason = 0;
    end else if (energy_valid && m_live) begin
      e = longint'($signed(energy_in));
      if (m_iters < 65535) m_iters = m_iters + 1;
      if (!m_seen || e < m_best) begin
        m_best = e; m_sig = sigma_in; m_acc = 1; m_stall = 0;
      end else begin
        m_rej = 1; m_stall = m_stall + 1;
      end
      m_seen = 1;
      m_reason[0] = (m_max != 0) && (m_iters == m_max);
      m_reason[1] = (m_stall == SL);
      if (m_reason != 0) begin
        m_live = 0;
        m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("best_energy", best_energy, m_best);
      chk_sig("best_sigma", best_sigma, m_sig);
      chk("accept", accept, m_acc);
      chk("reject", reject, m_rej);
      chk("iter_count", iter_count, m_iters);
      chk("stall_count", stall_count, m_stall);
      chk("busy", busy, m_live);
      chk("done", done, m_done);
      chk("done_reason", done_reason, m_reason);
    end
  end

  task automatic drive(input bit r, input bit s, input int mi, input bit v,
                       input longint e, input logic [VS-1:0] sg);
    @(negedge clk);
    rst          = r;
    start        = s;
    max_iters    = 16'(mi);
    energy_valid = v;
    energy_in    = EW'(e);
    sigma_in     = sg;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, '0);
  endtask

  function automatic logic [VS-1:0] rsig();
    logic [VS-1:0] r;
    for (int i = 0; i < VS / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  initial begin
    logic [VS-1:0] s0, s1, s2, s3;
    rst = 1; start = 0; max_iters = 0; energy_valid = 0; energy_in = 0; sigma_in = '0;
    s0 = rsig(); s1 = rsig(); s2 = rsig(); s3 = rsig();

    drive(1, 0, 0, 0, 0, '0);
    idle();
    chk("lit_rst_best", best_energy, EMAX);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_done", done, 0);

    // Iteration limit: -10, -12, -12, -5 with max_iters=4.
    drive(0, 1, 4, 0, 0, '0);
    drive(0, 0, 0, 1, -10, s0);
    drive(0, 0, 0, 1, -12, s1);
    chk("lit_t1_acc0", accept, 1);
    drive(0, 0, 0, 1, -12, s2);
    chk("lit_t1_acc1", accept, 1);
    drive(0, 0, 0, 1, -5, s3);
    chk("lit_t1_rej2", reject, 1);
    idle();
    chk("lit_t1_rej3", reject, 1);
    chk("lit_t1_best", best_energy, -12);
    chk_sig("lit_t1_sig", best_sigma, s1);
    chk("lit_t1_iter", iter_count, 4);
    chk("lit_t1_reason", done_reason, 1);
    chk("lit_t1_done", done, 1);

    // Stall limit: 5, 7, 5, 9 unlimited iterations.
    drive(0, 1, 0, 0, 0, '0);
    drive(0, 0, 0, 1, 5, s0);
    drive(0, 0, 0, 1, 7, s1);
    drive(0, 0, 0, 1, 5, s2);
    drive(0, 0, 0, 1, 9, s3);
    chk("lit_t2_eq_rej", reject, 1);
    chk("lit_t2_stall2", stall_count, 2);
    chk("lit_t2_notdone", done, 0);
    idle();
    chk("lit_t2_done", done, 1);
    chk("lit_t2_stall", stall_count, 3);
    chk("lit_t2_reason", done_reason, 2);
    // Evaluations after the run ends are ignored.
    drive(0, 0, 0, 1, -1000, s0);
    idle();
    chk("lit_dn_acc", accept, 0);
    chk("lit_dn_rej", reject, 0);
    chk("lit_dn_best", best_energy, 5);
    chk("lit_dn_iter", iter_count, 4);

    // Both limits at once.
    drive(0, 1, 4, 0, 0, '0);
    for (int i = 1; i <= 4; i++) drive(0, 0, 0, 1, i, s0);
    idle();
    chk("lit_t3_reason", done_reason, 3);

    // Signed extremes at full rate.
    drive(0, 1, 0, 0, 0, '0);
    drive(0, 0, 0, 1, EMIN, s0);
    drive(0, 0, 0, 1, EMAX, s1);
    chk("lit_t4_acc", accept, 1);
    idle();
    chk("lit_t4_rej", reject, 1);
    chk("lit_t4_best", best_energy, EMIN);
    chk_sig("lit_t4_sig", best_sigma, s0);

    // Restart coincident with a valid.
    drive(0, 1, 0, 0, 0, '0);
    drive(0, 0, 0, 1, 3, s0);
    drive(0, 0, 0, 1, 2, s1);
    drive(0, 1, 0, 1, -100, s2);
    idle();
    chk("lit_t5_busy", busy, 1);
    chk("lit_t5_iter", iter_count, 0);
    chk("lit_t5_acc", accept, 0);
    chk("lit_t5_best", best_energy, EMAX);

    // Reset between two valids in a run.
    drive(0, 0, 0, 1, 1, s0);
    drive(0, 0, 0, 1, 0, s1);
    drive(1, 0, 0, 0, 0, '0);
    drive(0, 0, 0, 1, -50, s2);
    idle();
    chk("lit_t6_best", best_energy, EMAX);
    chk("lit_t6_busy", busy, 0);
    chk("lit_t6_iter", iter_count, 0);
    chk("lit_t6_acc", accept, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bit r, s, v;
      int mi;
      longint e;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 2) != 0);
      mi = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 10));
      if ($urandom_range(0, 9) == 0)
        e = ($urandom_range(0, 1) == 0) ? EMIN : EMAX;
      else
        e = longint'($urandom_range(0, 40)) - 20;
      drive(r, s, mi, v, e, rsig());
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
